// File: rtl/blackjack_pkg.sv
// Shared constants for the blackjack deck sequencer: deck geometry, FSM encoding,
// deal destinations, LFSR taps and card rank/points helpers.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int LFSR_W    = 8;

  // Galois right-shift toggle mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [5:0] LAST_IDX   = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL_DECK  = 6'(DECK_SIZE);
  localparam logic [5:0] SUIT_SIZE  = 6'd13;
  localparam logic [3:0] FACE_POINTS = 4'd10;

  localparam logic DEST_PLAYER = 1'b0;
  localparam logic DEST_DEALER = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT    = 2'd1,
    ST_SHUFFLE = 2'd2,
    ST_READY   = 2'd3
  } state_t;

  // Smallest 2^k-1 covering i, so a masked draw rejects less than half the time
  function automatic logic [5:0] draw_mask(input logic [5:0] i);
    if (i >= 6'd32)      return 6'd63;
    else if (i >= 6'd16) return 6'd31;
    else if (i >= 6'd8)  return 6'd15;
    else if (i >= 6'd4)  return 6'd7;
    else if (i >= 6'd2)  return 6'd3;
    else                 return 6'd1;
  endfunction

  function automatic logic [3:0] rank_of(input logic [5:0] id);
    return 4'(id % SUIT_SIZE) + 4'd1;
  endfunction

  function automatic logic [3:0] points_of(input logic [3:0] rank);
    return (rank > FACE_POINTS) ? FACE_POINTS : rank;
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// Galois LFSR random source for the shuffle: synchronous load, step on enable.
module lfsr_rng
  import blackjack_pkg::*;
#(
  parameter int W = LFSR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= {{(W-1){1'b0}}, 1'b1};
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= {1'b0, value[W-1:1]} ^ (value[0] ? W'(LFSR_TAPS) : '0);
    end
  end

endmodule

// File: rtl/deck_shuffle_sequencer.sv
// Deck store with identity init, LFSR-driven Fisher-Yates shuffle and round-robin
// player/dealer dealing. Define CARD_RANK_OUT_EN to add card_rank/card_points outputs.
//
// state   | meaning
// IDLE    | after reset, requests ignored until start_shuffle
// INIT    | writing deck[i]=i, one entry per cycle
// SHUFFLE | one masked draw per cycle; accepted draws swap and step i down
// READY   | dealing cards to player/dealer, one grant per cycle at most
module deck_shuffle_sequencer
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_shuffle,
  input  logic [5:0] seed,
  input  logic       player_req,
  input  logic       dealer_req,
  output logic       player_gnt,
  output logic       dealer_gnt,
  output logic       card_valid,
  output logic [5:0] card_id,
  output logic       card_dest,
  output logic       busy,
  output logic       ready,
  output logic       deck_empty,
  output logic [5:0] cards_left,
  output logic [1:0] state_out
`ifdef CARD_RANK_OUT_EN
  ,
  output logic [3:0] card_rank,
  output logic [3:0] card_points
`endif
);

  state_t state, state_next;

  logic [5:0]        deck [DECK_SIZE];
  logic [5:0]        idx;
  logic [5:0]        deal_ptr;
  logic [LFSR_W-1:0] lfsr;
  logic [5:0]        draw;
  logic              accept;
  logic              rr_ptr;
  logic              elig_p, elig_d, grant_any, grant_dest;
  logic              unused_lfsr;

  lfsr_rng #(.W(LFSR_W)) u_rng (
    .clk      (clk),
    .rst      (rst),
    .load     (start_shuffle),
    .load_val (LFSR_W'({seed, 2'b01})),
    .step     (state == ST_SHUFFLE && !start_shuffle),
    .value    (lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:6];

  always_comb begin
    draw   = lfsr[5:0] & draw_mask(idx);
    accept = (state == ST_SHUFFLE) && (draw <= idx);
    // A requester whose grant is showing this cycle sits out one cycle
    elig_p     = player_req && !player_gnt;
    elig_d     = dealer_req && !dealer_gnt;
    grant_any  = (state == ST_READY) && (cards_left != 6'd0) && !start_shuffle
                 && (elig_p || elig_d);
    grant_dest = (elig_p && elig_d) ? rr_ptr : elig_d;
  end

  always_comb begin
    state_next = state;
    if (start_shuffle) begin
      state_next = ST_INIT;
    end else begin
      case (state)
        ST_INIT:    if (idx == LAST_IDX) state_next = ST_SHUFFLE;
        ST_SHUFFLE: if (accept && idx == 6'd1) state_next = ST_READY;
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      deal_ptr   <= '0;
      cards_left <= '0;
      rr_ptr     <= DEST_PLAYER;
      player_gnt <= 1'b0;
      dealer_gnt <= 1'b0;
      card_valid <= 1'b0;
      card_id    <= '0;
      card_dest  <= 1'b0;
    end else begin
      player_gnt <= grant_any && (grant_dest == DEST_PLAYER);
      dealer_gnt <= grant_any && (grant_dest == DEST_DEALER);
      card_valid <= grant_any;
      card_id    <= grant_any ? deck[deal_ptr] : '0;
      card_dest  <= grant_any ? grant_dest : 1'b0;
      if (start_shuffle) begin
        idx        <= '0;
        deal_ptr   <= '0;
        cards_left <= '0;
      end else begin
        case (state)
          ST_INIT: if (idx != LAST_IDX) idx <= idx + 6'd1;
          ST_SHUFFLE: begin
            if (accept) begin
              if (idx == 6'd1) begin
                cards_left <= FULL_DECK;
                deal_ptr   <= '0;
              end else begin
                idx <= idx - 6'd1;
              end
            end
          end
          ST_READY: begin
            if (grant_any) begin
              deal_ptr   <= deal_ptr + 6'd1;
              cards_left <= cards_left - 6'd1;
              rr_ptr     <= ~grant_dest;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Deck contents need no reset; INIT rewrites every entry before use
  always_ff @(posedge clk) begin
    if (!start_shuffle) begin
      if (state == ST_INIT) begin
        deck[idx] <= idx;
      end else if (accept) begin
        deck[idx]  <= deck[draw];
        deck[draw] <= deck[idx];
      end
    end
  end

`ifdef CARD_RANK_OUT_EN
  always_ff @(posedge clk) begin
    if (rst || !grant_any) begin
      card_rank   <= '0;
      card_points <= '0;
    end else begin
      card_rank   <= rank_of(deck[deal_ptr]);
      card_points <= points_of(rank_of(deck[deal_ptr]));
    end
  end
`endif

  assign busy       = (state == ST_INIT) || (state == ST_SHUFFLE);
  assign ready      = (state == ST_READY) && (cards_left != 6'd0);
  assign deck_empty = (state == ST_READY) && (cards_left == 6'd0);
  assign state_out  = state;

endmodule

// File: tb/tb_deck_shuffle_sequencer.sv
// Self-checking bench for deck_shuffle_sequencer: reset/idle vector table, directed
// shuffle/deal sequences and a randomized run against a behavioural deck model.
module tb_deck_shuffle_sequencer;

  logic       clk = 1'b0;
  logic       rst, start_shuffle, player_req, dealer_req;
  logic [5:0] seed;
  logic       player_gnt, dealer_gnt, card_valid, card_dest, busy, ready, deck_empty;
  logic [5:0] card_id, cards_left;
  logic [1:0] state_out;
`ifdef CARD_RANK_OUT_EN
  logic [3:0] card_rank, card_points;
`endif

  deck_shuffle_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start_shuffle (start_shuffle),
    .seed          (seed),
    .player_req    (player_req),
    .dealer_req    (dealer_req),
    .player_gnt    (player_gnt),
    .dealer_gnt    (dealer_gnt),
    .card_valid    (card_valid),
    .card_id       (card_id),
    .card_dest     (card_dest),
    .busy          (busy),
    .ready         (ready),
    .deck_empty    (deck_empty),
    .cards_left    (cards_left),
    .state_out     (state_out)
`ifdef CARD_RANK_OUT_EN
    ,
    .card_rank     (card_rank),
    .card_points   (card_points)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int m_order[52];
  int m_phase, m_busy_left, m_draws, m_left, m_ptr, m_id;
  bit m_pg, m_dg, m_valid, m_dest, m_last_dealer;

  function void compute_shuffle(int sd);
    int taps[4];
    int tapmask, lf, m, s, tmp;
    bit lsb, done;
    taps = '{8, 6, 5, 4};
    tapmask = 0;
    foreach (taps[t]) tapmask |= (1 << (taps[t] - 1));
    lf = (sd << 2) | 1;
    for (int k = 0; k < 52; k++) m_order[k] = k;
    m_draws = 0;
    for (int i = 51; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      done = 0;
      while (!done) begin
        s   = (lf % 64) & m;
        lsb = lf[0];
        lf  = lf >> 1;
        if (lsb) lf = lf ^ tapmask;
        m_draws++;
        if (s <= i) begin
          tmp = m_order[i]; m_order[i] = m_order[s]; m_order[s] = tmp;
          done = 1;
        end
      end
    end
  endfunction

  function void model_step();
    bit ep, ed;
    m_valid = 0;
    if (rst) begin
      m_phase = 0; m_left = 0; m_ptr = 0; m_last_dealer = 1; m_pg = 0; m_dg = 0;
      return;
    end
    if (start_shuffle) begin
      compute_shuffle(int'(seed));
      m_phase = 1; m_busy_left = 52 + m_draws; m_left = 0; m_ptr = 0; m_pg = 0; m_dg = 0;
    end else if (m_phase == 1 || m_phase == 2) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_phase = 3; m_left = 52; m_ptr = 0;
      end else begin
        m_phase = (m_busy_left <= m_draws) ? 2 : 1;
      end
      m_pg = 0; m_dg = 0;
    end else if (m_phase == 3 && m_left > 0) begin
      ep = player_req && !m_pg;
      ed = dealer_req && !m_dg;
      m_pg = 0; m_dg = 0;
      if (ep || ed) begin
        m_dest = (ep && ed) ? !m_last_dealer : ed;
        m_last_dealer = m_dest;
        m_valid = 1;
        m_id = m_order[m_ptr];
        m_ptr++; m_left--;
        if (m_dest) m_dg = 1; else m_pg = 1;
      end
    end else begin
      m_pg = 0; m_dg = 0;
    end
  endfunction

  function void compare();
    chk("state_out", state_out, m_phase);
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("ready", ready, (m_phase == 3 && m_left > 0));
    chk("deck_empty", deck_empty, (m_phase == 3 && m_left == 0));
    chk("cards_left", cards_left, m_left);
    chk("player_gnt", player_gnt, (m_valid && !m_dest));
    chk("dealer_gnt", dealer_gnt, (m_valid && m_dest));
    chk("card_valid", card_valid, m_valid);
    if (m_valid) begin
      chk("card_id", card_id, m_id);
      chk("card_dest", card_dest, m_dest);
`ifdef CARD_RANK_OUT_EN
      chk("card_rank", card_rank, (m_id % 13) + 1);
      chk("card_points", card_points, ((m_id % 13) + 1 > 10) ? 10 : (m_id % 13) + 1);
    end else begin
      chk("card_rank_idle", card_rank, 0);
      chk("card_points_idle", card_points, 0);
`endif
    end
  endfunction

  // ---------------- cycle stepping and deal capture ----------------
  int cyc = 0;
  int seq_cur[52];
  int n_cur, g_first, g_last;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    cyc++;
    if (card_valid && n_cur < 52) begin
      if (n_cur == 0) g_first = cyc;
      g_last = cyc;
      seq_cur[n_cur] = int'(card_id);
      n_cur++;
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input int sd);
    seed = 6'(sd);
    start_shuffle = 1'b1;
    tick();
    start_shuffle = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 3000 && !ready; k++) tick();
    chk("wait_ready", ready, 1);
  endtask

  task automatic collect(input bit p, input bit d);
    int seen[52];
    int bad;
    n_cur = 0; g_first = 0; g_last = 0;
    player_req = p; dealer_req = d;
    for (int k = 0; k < 3000 && n_cur < 52; k++) tick();
    chk("collect_count", n_cur, 52);
    chk(p && d ? "both_req_spacing" : "single_req_spacing", g_last - g_first, p && d ? 51 : 102);
    foreach (seen[k]) seen[k] = 0;
    for (int k = 0; k < n_cur; k++) seen[seq_cur[k]]++;
    bad = 0;
    foreach (seen[k]) if (seen[k] != 1) bad++;
    chk("permutation", bad, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("deck_empty_after_deal", deck_empty, 1);
    chk("ready_after_deal", ready, 0);
    chk("no_grant_when_empty", player_gnt | dealer_gnt, 0);
  endtask

  // ---------------- reset / idle vector table ----------------
  typedef struct {
    bit         rst;
    bit         start;
    bit         preq;
    bit         dreq;
    logic [5:0] seed;
    int         exp_state;
    bit         exp_busy;
  } vec_t;

  vec_t vt[8];
  int   seq_a[52];
  int   diff;
  bit   prev_pg;

  initial begin
    rst = 1'b1; start_shuffle = 1'b0; player_req = 1'b0; dealer_req = 1'b0; seed = '0;
    n_cur = 0;

    vt[0] = '{1, 0, 1, 0, 6'd0, 0, 0};
    vt[1] = '{1, 0, 1, 0, 6'd0, 0, 0};
    vt[2] = '{1, 0, 1, 0, 6'd0, 0, 0};
    vt[3] = '{0, 0, 0, 0, 6'd0, 0, 0};
    vt[4] = '{0, 0, 1, 0, 6'd0, 0, 0};
    vt[5] = '{0, 0, 1, 1, 6'd3, 0, 0};
    vt[6] = '{0, 1, 1, 0, 6'b001010, 1, 1};
    vt[7] = '{0, 0, 1, 0, 6'd0, 1, 1};

    foreach (vt[r]) begin
      rst = vt[r].rst; start_shuffle = vt[r].start;
      player_req = vt[r].preq; dealer_req = vt[r].dreq; seed = vt[r].seed;
      tick();
      chk("vec_state", state_out, vt[r].exp_state);
      chk("vec_busy", busy, vt[r].exp_busy);
      chk("vec_quiet", player_gnt | dealer_gnt | card_valid | ready | deck_empty | (cards_left != 0), 0);
      if (vt[r].rst) chk("vec_reset_card_id", card_id, 0);
    end
    start_shuffle = 1'b0;

    // seed 10, player only: every id exactly once, grants every other cycle
    collect(1, 0);
    seq_a = seq_cur;

    // same seed again with player_req still held: same order, nothing before READY
    pulse_start(6'b001010);
    chk("restart_clears_cards", cards_left, 0);
    collect(1, 0);
    diff = 0;
    for (int k = 0; k < 52; k++) if (seq_cur[k] != seq_a[k]) diff++;
    chk("same_seed_same_order", diff, 0);

    // seed 1, both requesters held: alternating back-to-back grants
    pulse_start(6'b000001);
    collect(1, 1);
    diff = 0;
    for (int k = 0; k < 52; k++) if (seq_cur[k] != seq_a[k]) diff++;
    chk("other_seed_differs", diff != 0, 1);

    // restart mid-SHUFFLE
    player_req = 1'b0; dealer_req = 1'b0;
    pulse_start(5);
    for (int k = 0; k < 70; k++) tick();
    chk("mid_shuffle_state", state_out, 2);
    pulse_start(7);
    chk("restart_from_shuffle", state_out, 1);
    chk("restart_from_shuffle_left", cards_left, 0);

    // restart mid-deal with player_req held
    wait_ready();
    player_req = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    pulse_start(33);
    chk("restart_from_ready", state_out, 1);
    chk("restart_from_ready_left", cards_left, 0);
    chk("restart_from_ready_valid", card_valid, 0);
    collect(1, 0);

    // randomized traffic against the model
    player_req = 1'b0; dealer_req = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      rst = ($urandom_range(0, 2499) == 0);
      start_shuffle = ($urandom_range(0, 299) == 0);
      seed = 6'($urandom_range(0, 63));
      if (player_gnt) player_req = ($urandom_range(0, 3) == 0);
      else if (!player_req) player_req = ($urandom_range(0, 2) == 0);
      if (dealer_gnt) dealer_req = ($urandom_range(0, 3) == 0);
      else if (!dealer_req) dealer_req = ($urandom_range(0, 2) == 0);
      if (k % 1000 == 0) begin
        start_shuffle = 1'b1;
        rst = 1'b0;
      end
      prev_pg = player_gnt;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
